// File: rtl/ring_pattern_pkg.sv
// Shared encodings and the per-mode period helper for the ring pattern generator.
package ring_pattern_pkg;

    localparam logic [1:0] MODE_ROTL   = 2'b00;
    localparam logic [1:0] MODE_ROTR   = 2'b01;
    localparam logic [1:0] MODE_BOUNCE = 2'b10;
    localparam logic [1:0] MODE_FILL   = 2'b11;

    typedef enum logic {
        DIR_LEFT  = 1'b0,
        DIR_RIGHT = 1'b1
    } dir_e;

    typedef enum logic {
        PHASE_FILL  = 1'b0,
        PHASE_CLEAR = 1'b1
    } phase_e;

    // Number of steps after which the pattern of a mode repeats.
    function automatic int unsigned period(input int unsigned width, input logic [1:0] mode);
        int unsigned p;
        case (mode)
            MODE_ROTL, MODE_ROTR: p = width;
            MODE_BOUNCE:          p = 2 * width - 2;
            default:              p = 2 * width;
        endcase
        return p;
    endfunction

endpackage

// File: rtl/ring_pattern_gen_prescaler.sv
// Enabled prescaler: asserts tick_c on every DIV+1-th enabled cycle.
module tick_prescaler #(
    parameter int unsigned DIV_W = 16
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             en_i,
    input  logic             clr_i,
    input  logic [DIV_W-1:0] div_i,
    output logic             tick_c
);

    logic [DIV_W-1:0] cnt_q;
    logic [DIV_W-1:0] cnt_d;

    // >= rather than == so a DIV lowered below the count ticks right away.
    assign tick_c = en_i && (cnt_q >= div_i);

    // Next count: clear wins, wrap on tick, otherwise count enabled cycles.
    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (tick_c) begin
            cnt_d = '0;
        end else if (en_i) begin
            cnt_d = cnt_q + DIV_W'(1);
        end
    end

    // Count register with synchronous reset.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/ring_pattern_gen.sv
// Rotating / bouncing / fill-clear pattern generator with load, enable and status pulses.
module ring_pattern_gen
    import ring_pattern_pkg::*;
#(
    parameter int unsigned     WIDTH = 8,
    parameter int unsigned     DIV_W = 16,
    parameter logic [WIDTH-1:0] INIT = {{(WIDTH-1){1'b0}}, 1'b1}
) (
    input  logic             CLK_MUX,
    input  logic             RST_N,
    input  logic             EN,
    input  logic [1:0]       MODE,
    input  logic [DIV_W-1:0] DIV,
    input  logic             LOAD,
    input  logic [WIDTH-1:0] LDATA,
    output logic [WIDTH-1:0] LOUT,
    output logic             STEP,
    output logic             WRAP
);

    localparam int unsigned SCNT_W = $clog2(2 * WIDTH);

    logic [WIDTH-1:0]  lout_q;
    logic [WIDTH-1:0]  lout_d;
    dir_e              dir_q;
    dir_e              dir_d;
    phase_e            phase_q;
    phase_e            phase_d;
    logic [1:0]        mode_q;
    logic [SCNT_W-1:0] scnt_q;
    logic              step_q;
    logic              wrap_q;

    logic              tick_c;
    logic              mode_chg_c;
    logic              wrap_c;

    // RST_N is active-high despite its name (legacy board net).
    tick_prescaler #(
        .DIV_W (DIV_W)
    ) u_prescaler (
        .clk_i  (CLK_MUX),
        .rst_i  (RST_N),
        .en_i   (EN),
        .clr_i  (LOAD),
        .div_i  (DIV),
        .tick_c (tick_c)
    );

    assign mode_chg_c = EN && (MODE != mode_q);
    assign wrap_c     = (scnt_q == SCNT_W'(period(WIDTH, mode_q) - 1));

    // Pattern, direction and phase that a step in the current mode would produce.
    always_comb begin
        lout_d  = lout_q;
        dir_d   = dir_q;
        phase_d = phase_q;
        case (mode_q)
            MODE_ROTL: lout_d = {lout_q[WIDTH-2:0], lout_q[WIDTH-1]};
            MODE_ROTR: lout_d = {lout_q[0], lout_q[WIDTH-1:1]};
            MODE_BOUNCE: begin
                // Turn around on the step that would push the edge bit out.
                if (dir_q == DIR_LEFT) begin
                    if (lout_q[WIDTH-1]) begin
                        dir_d  = DIR_RIGHT;
                        lout_d = lout_q >> 1;
                    end else begin
                        lout_d = lout_q << 1;
                    end
                end else begin
                    if (lout_q[0]) begin
                        dir_d  = DIR_LEFT;
                        lout_d = lout_q << 1;
                    end else begin
                        lout_d = lout_q >> 1;
                    end
                end
            end
            default: begin
                if (phase_q == PHASE_FILL) begin
                    lout_d = {lout_q[WIDTH-2:0], 1'b1};
                    if (&lout_d) begin
                        phase_d = PHASE_CLEAR;
                    end
                end else begin
                    lout_d = {lout_q[WIDTH-2:0], 1'b0};
                    if (lout_d == '0) begin
                        phase_d = PHASE_FILL;
                    end
                end
            end
        endcase
    end

    // State update in priority order: reset, load, mode change, step.
    always_ff @(posedge CLK_MUX) begin
        if (RST_N) begin
            lout_q  <= INIT;
            dir_q   <= DIR_LEFT;
            phase_q <= PHASE_FILL;
            mode_q  <= MODE;
            scnt_q  <= '0;
            step_q  <= 1'b0;
            wrap_q  <= 1'b0;
        end else begin
            step_q <= 1'b0;
            wrap_q <= 1'b0;
            if (LOAD) begin
                lout_q  <= LDATA;
                dir_q   <= DIR_LEFT;
                phase_q <= PHASE_FILL;
                mode_q  <= MODE;
                scnt_q  <= '0;
            end else if (mode_chg_c) begin
                dir_q   <= DIR_LEFT;
                phase_q <= PHASE_FILL;
                mode_q  <= MODE;
                scnt_q  <= '0;
            end else if (tick_c) begin
                lout_q  <= lout_d;
                dir_q   <= dir_d;
                phase_q <= phase_d;
                step_q  <= 1'b1;
                wrap_q  <= wrap_c;
                scnt_q  <= wrap_c ? '0 : scnt_q + SCNT_W'(1);
            end
        end
    end

    assign LOUT = lout_q;
    assign STEP = step_q;
    assign WRAP = wrap_q;

endmodule

// File: tb/tb_ring_pattern_gen.sv
// Directed bench for ring_pattern_gen at WIDTH=8.
module tb_ring_pattern_gen;

    logic        CLK_MUX;
    logic        RST_N;
    logic        EN;
    logic [1:0]  MODE;
    logic [15:0] DIV;
    logic        LOAD;
    logic [7:0]  LDATA;
    logic [7:0]  LOUT;
    logic        STEP;
    logic        WRAP;

    int n_tests = 0;
    int n_fail  = 0;

    ring_pattern_gen #(
        .WIDTH (8),
        .DIV_W (16)
    ) dut (
        .CLK_MUX (CLK_MUX),
        .RST_N   (RST_N),
        .EN      (EN),
        .MODE    (MODE),
        .DIV     (DIV),
        .LOAD    (LOAD),
        .LDATA   (LDATA),
        .LOUT    (LOUT),
        .STEP    (STEP),
        .WRAP    (WRAP)
    );

    initial begin
        CLK_MUX = 1'b0;
        forever #5 CLK_MUX = ~CLK_MUX;
    end

    // Advance one edge and settle; inputs change here, outputs are sampled here.
    task automatic cyc();
        @(posedge CLK_MUX);
        #1;
    endtask

    task automatic test_reset();
        RST_N = 1'b1; EN = 1'b0; MODE = 2'b00; DIV = 16'd0; LOAD = 1'b0; LDATA = 8'h00;
        cyc();
        cyc();
        n_tests++;
        if (LOUT !== 8'h01) begin n_fail++; $display("FAIL reset_lout got %h want 01", LOUT); end
        n_tests++;
        if (STEP !== 1'b0 || WRAP !== 1'b0) begin
            n_fail++; $display("FAIL reset_pulses got step=%b wrap=%b want 0 0", STEP, WRAP);
        end
    endtask

    task automatic test_rotl();
        logic [7:0] seq [8];
        seq = '{8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80, 8'h01};
        RST_N = 1'b0; EN = 1'b1;
        for (int i = 0; i < 8; i++) begin
            cyc();
            n_tests++;
            if (LOUT !== seq[i] || STEP !== 1'b1 || WRAP !== (i == 7)) begin
                n_fail++;
                $display("FAIL rotl_step%0d got lout=%h step=%b wrap=%b want lout=%h step=1 wrap=%b",
                         i, LOUT, STEP, WRAP, seq[i], (i == 7));
            end
        end
    endtask

    task automatic test_rotr_en();
        logic [7:0] exp_l;
        logic       exp_s;
        RST_N = 1'b1; MODE = 2'b01; DIV = 16'd2; EN = 1'b1;
        cyc();
        RST_N = 1'b0;
        exp_l = 8'h01;
        for (int c = 1; c <= 9; c++) begin
            cyc();
            exp_s = (c % 3 == 0);
            if (exp_s) exp_l = {exp_l[0], exp_l[7:1]};
            n_tests++;
            if (LOUT !== exp_l || STEP !== exp_s || WRAP !== 1'b0) begin
                n_fail++;
                $display("FAIL rotr_cyc%0d got lout=%h step=%b wrap=%b want lout=%h step=%b wrap=0",
                         c, LOUT, STEP, WRAP, exp_l, exp_s);
            end
        end
        EN = 1'b0;
        for (int c = 0; c < 5; c++) begin
            cyc();
            n_tests++;
            if (LOUT !== 8'h20 || STEP !== 1'b0 || WRAP !== 1'b0) begin
                n_fail++;
                $display("FAIL rotr_frozen%0d got lout=%h step=%b wrap=%b want lout=20 step=0 wrap=0",
                         c, LOUT, STEP, WRAP);
            end
        end
        EN = 1'b1;
        for (int c = 1; c <= 3; c++) begin
            cyc();
            exp_s = (c == 3);
            exp_l = exp_s ? 8'h10 : 8'h20;
            n_tests++;
            if (LOUT !== exp_l || STEP !== exp_s) begin
                n_fail++;
                $display("FAIL rotr_resume%0d got lout=%h step=%b want lout=%h step=%b",
                         c, LOUT, STEP, exp_l, exp_s);
            end
        end
    endtask

    task automatic test_bounce();
        logic [7:0] seq [15];
        seq = '{8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80,
                8'h40, 8'h20, 8'h10, 8'h08, 8'h04, 8'h02, 8'h01, 8'h02};
        RST_N = 1'b1; MODE = 2'b10; DIV = 16'd0; EN = 1'b1;
        cyc();
        RST_N = 1'b0;
        for (int i = 0; i < 15; i++) begin
            cyc();
            n_tests++;
            if (LOUT !== seq[i] || STEP !== 1'b1 || WRAP !== (i == 13)) begin
                n_fail++;
                $display("FAIL bounce_step%0d got lout=%h step=%b wrap=%b want lout=%h step=1 wrap=%b",
                         i + 1, LOUT, STEP, WRAP, seq[i], (i == 13));
            end
        end
    endtask

    task automatic test_reset_mid();
        // Seven more steps from 02 moving left lands on 40 moving right.
        for (int i = 0; i < 7; i++) cyc();
        n_tests++;
        if (LOUT !== 8'h40) begin n_fail++; $display("FAIL midbounce_lout got %h want 40", LOUT); end
        RST_N = 1'b1;
        cyc();
        n_tests++;
        if (LOUT !== 8'h01 || STEP !== 1'b0 || WRAP !== 1'b0) begin
            n_fail++;
            $display("FAIL midreset got lout=%h step=%b wrap=%b want lout=01 step=0 wrap=0", LOUT, STEP, WRAP);
        end
        RST_N = 1'b0;
        for (int i = 1; i <= 14; i++) begin
            cyc();
            n_tests++;
            if (WRAP !== (i == 14)) begin
                n_fail++; $display("FAIL midreset_wrap_step%0d got %b want %b", i, WRAP, (i == 14));
            end
        end
        n_tests++;
        if (LOUT !== 8'h01) begin n_fail++; $display("FAIL midreset_period_end got %h want 01", LOUT); end
    endtask

    task automatic test_fill();
        logic [7:0] seq [17];
        seq = '{8'h01, 8'h03, 8'h07, 8'h0F, 8'h1F, 8'h3F, 8'h7F, 8'hFF,
                8'hFE, 8'hFC, 8'hF8, 8'hF0, 8'hE0, 8'hC0, 8'h80, 8'h00, 8'h01};
        MODE = 2'b11;
        cyc();
        n_tests++;
        if (LOUT !== 8'h01 || STEP !== 1'b0) begin
            n_fail++; $display("FAIL fill_modechg got lout=%h step=%b want lout=01 step=0", LOUT, STEP);
        end
        LOAD = 1'b1; LDATA = 8'h00;
        cyc();
        LOAD = 1'b0;
        n_tests++;
        if (LOUT !== 8'h00 || STEP !== 1'b0) begin
            n_fail++; $display("FAIL fill_load got lout=%h step=%b want lout=00 step=0", LOUT, STEP);
        end
        for (int i = 0; i < 17; i++) begin
            cyc();
            n_tests++;
            if (LOUT !== seq[i] || STEP !== 1'b1 || WRAP !== (i == 15)) begin
                n_fail++;
                $display("FAIL fill_step%0d got lout=%h step=%b wrap=%b want lout=%h step=1 wrap=%b",
                         i + 1, LOUT, STEP, WRAP, seq[i], (i == 15));
            end
        end
    endtask

    task automatic test_load_tick();
        // DIV=0 so every enabled cycle is a tick; LOAD must win.
        LOAD = 1'b1; LDATA = 8'hA5; EN = 1'b1;
        cyc();
        n_tests++;
        if (LOUT !== 8'hA5 || STEP !== 1'b0 || WRAP !== 1'b0) begin
            n_fail++;
            $display("FAIL load_tick got lout=%h step=%b wrap=%b want lout=a5 step=0 wrap=0", LOUT, STEP, WRAP);
        end
        EN = 1'b0; LDATA = 8'h3C;
        cyc();
        n_tests++;
        if (LOUT !== 8'h3C || STEP !== 1'b0) begin
            n_fail++; $display("FAIL load_disabled got lout=%h step=%b want lout=3c step=0", LOUT, STEP);
        end
        LOAD = 1'b0; EN = 1'b1;
        cyc();
        n_tests++;
        if (LOUT !== 8'h79 || STEP !== 1'b1) begin
            n_fail++; $display("FAIL load_then_fill got lout=%h step=%b want lout=79 step=1", LOUT, STEP);
        end
    endtask

    task automatic test_mode_change_wrap();
        logic [7:0] seq [8];
        seq = '{8'hCF, 8'h9F, 8'h3F, 8'h7E, 8'hFC, 8'hF9, 8'hF3, 8'hE7};
        cyc();
        cyc();
        n_tests++;
        if (LOUT !== 8'hE7) begin n_fail++; $display("FAIL prechange_lout got %h want e7", LOUT); end
        MODE = 2'b00;
        cyc();
        n_tests++;
        if (LOUT !== 8'hE7 || STEP !== 1'b0 || WRAP !== 1'b0) begin
            n_fail++;
            $display("FAIL modechg_cycle got lout=%h step=%b wrap=%b want lout=e7 step=0 wrap=0", LOUT, STEP, WRAP);
        end
        for (int i = 0; i < 8; i++) begin
            cyc();
            n_tests++;
            if (LOUT !== seq[i] || STEP !== 1'b1 || WRAP !== (i == 7)) begin
                n_fail++;
                $display("FAIL modechg_step%0d got lout=%h step=%b wrap=%b want lout=%h step=1 wrap=%b",
                         i + 1, LOUT, STEP, WRAP, seq[i], (i == 7));
            end
        end
    endtask

    initial begin
        test_reset();
        test_rotl();
        test_rotr_en();
        test_bounce();
        test_reset_mid();
        test_fill();
        test_load_tick();
        test_mode_change_wrap();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
